// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
package pipe_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned STATE_W       = 2;
  localparam int unsigned CTRL_W        = 9;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_MDBUSY  = 2'd2,
    ST_TRAP    = 2'd3
  } state_e;

  // Per-cycle pipeline control word: stage enables, bubble requests, trap redirect.
  typedef struct packed {
    logic en_pc;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
    logic redirect_trap;
  } ctrl_t;

  // Everything advances, nothing is bubbled.
  localparam ctrl_t CTRL_PASS   = ctrl_t'(9'b11111_000_0);
  // Whole pipeline holds.
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(9'b00000_000_0);

  // Front end held while a mul/div occupies EX; EX/MEM receives a bubble.
  function automatic ctrl_t ctrl_md_hold();
    ctrl_t c;
    c             = CTRL_PASS;
    c.en_pc       = 1'b0;
    c.en_ifid     = 1'b0;
    c.en_idex     = 1'b0;
    c.flush_exmem = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: counts i_inc cycles, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == {W{1'b1}});

  // Count up on request, clear on reset, hold once full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: resolves hazard, memory, mul/div and trap
// requests into stage enables and bubbles, and counts front-end stall cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             hz_flush_ifid,
  input  logic             hz_flush_idex,
  input  logic             imem_ready,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  input  logic             md_start_EX,
  input  logic             md_done,
  input  logic             trap_req,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMEM,
  output logic             redirect_trap,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e r_state;
  state_e w_state_nxt;
  ctrl_t  w_ctrl;
  logic   w_md_stall;
  logic   w_dmem_wait;

  // A mul/div that finishes in the same cycle it enters EX causes no stall.
  assign w_md_stall  = md_start_EX && !md_done;
  assign w_dmem_wait = dmem_req_MEM && !dmem_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode; reset forces everything quiet.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = CTRL_PASS;

    unique case (r_state)
      ST_RUN: begin
        if (trap_req) begin
          w_ctrl.en_memwb      = 1'b0;
          w_ctrl.flush_ifid    = 1'b1;
          w_ctrl.flush_idex    = 1'b1;
          w_ctrl.flush_exmem   = 1'b1;
          w_ctrl.redirect_trap = 1'b1;
          w_state_nxt          = ST_TRAP;
        end else if (w_dmem_wait) begin
          w_ctrl      = CTRL_FREEZE;
          w_state_nxt = ST_MEMWAIT;
        end else if (w_md_stall) begin
          w_ctrl      = ctrl_md_hold();
          w_state_nxt = ST_MDBUSY;
        end else if (hz_stall) begin
          // Fetch is frozen here, so a pending IF/ID flush is not applied.
          w_ctrl.en_pc      = 1'b0;
          w_ctrl.en_ifid    = 1'b0;
          w_ctrl.flush_idex = hz_flush_idex;
        end else begin
          w_ctrl.en_pc      = imem_ready;
          w_ctrl.flush_ifid = !imem_ready || hz_flush_ifid;
        end
      end
      ST_MEMWAIT: begin
        if (!dmem_ready) begin
          w_ctrl = CTRL_FREEZE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MDBUSY: begin
        if (!md_done) begin
          w_ctrl = ctrl_md_hold();
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_TRAP: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    if (rst) begin
      w_ctrl      = CTRL_FREEZE;
      w_state_nxt = ST_RUN;
    end
  end

  assign en_PC         = w_ctrl.en_pc;
  assign en_IFID       = w_ctrl.en_ifid;
  assign en_IDEX       = w_ctrl.en_idex;
  assign en_EXMEM      = w_ctrl.en_exmem;
  assign en_MEMWB      = w_ctrl.en_memwb;
  assign flush_IFID    = w_ctrl.flush_ifid;
  assign flush_IDEX    = w_ctrl.flush_idex;
  assign flush_EXMEM   = w_ctrl.flush_exmem;
  assign redirect_trap = w_ctrl.redirect_trap;
  assign state         = r_state;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (!w_ctrl.en_pc),
    .o_count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked every
// cycle against a rule-level model; a 4-bit-counter instance covers saturation.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst, hz_stall, hz_flush_ifid, hz_flush_idex, imem_ready;
  logic dmem_req_MEM, dmem_ready, md_start_EX, md_done, trap_req;

  // {en_PC,en_IFID,en_IDEX,en_EXMEM,en_MEMWB,flush_IFID,flush_IDEX,flush_EXMEM,redirect_trap}
  logic [8:0]  c16, c4;
  logic [1:0]  st16, st4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;

  // Model state.
  int m_mode = 0;   // 0 run, 1 memwait, 2 mdbusy, 3 trap
  int m_cnt  = 0;
  int m_cnt4 = 0;

  always #5 clk = ~clk;

  pipe_ctrl u_dut16 (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .hz_flush_ifid(hz_flush_ifid),
    .hz_flush_idex(hz_flush_idex), .imem_ready(imem_ready), .dmem_req_MEM(dmem_req_MEM),
    .dmem_ready(dmem_ready), .md_start_EX(md_start_EX), .md_done(md_done), .trap_req(trap_req),
    .en_PC(c16[8]), .en_IFID(c16[7]), .en_IDEX(c16[6]), .en_EXMEM(c16[5]), .en_MEMWB(c16[4]),
    .flush_IFID(c16[3]), .flush_IDEX(c16[2]), .flush_EXMEM(c16[1]), .redirect_trap(c16[0]),
    .state(st16), .stall_cnt(cnt16)
  );

  pipe_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .hz_flush_ifid(hz_flush_ifid),
    .hz_flush_idex(hz_flush_idex), .imem_ready(imem_ready), .dmem_req_MEM(dmem_req_MEM),
    .dmem_ready(dmem_ready), .md_start_EX(md_start_EX), .md_done(md_done), .trap_req(trap_req),
    .en_PC(c4[8]), .en_IFID(c4[7]), .en_IDEX(c4[6]), .en_EXMEM(c4[5]), .en_MEMWB(c4[4]),
    .flush_IFID(c4[3]), .flush_IDEX(c4[2]), .flush_EXMEM(c4[1]), .redirect_trap(c4[0]),
    .state(st4), .stall_cnt(cnt4)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected control word and next mode from the priority rules.
  task automatic model_eval(output logic [8:0] c, output int nx);
    c  = 9'b11111_000_0;
    nx = 0;
    if (rst) begin
      c = '0;
    end else begin
      case (m_mode)
        0: begin
          if (trap_req) begin
            c = 9'b11110_111_1; nx = 3;
          end else if (dmem_req_MEM && !dmem_ready) begin
            c = '0; nx = 1;
          end else if (md_start_EX && !md_done) begin
            c = 9'b00011_001_0; nx = 2;
          end else if (hz_stall) begin
            c = {5'b00111, 1'b0, hz_flush_idex, 2'b00};
          end else begin
            c[8] = imem_ready;
            c[3] = !imem_ready || hz_flush_ifid;
          end
        end
        1: if (!dmem_ready) begin c = '0; nx = 1; end
        2: if (!md_done) begin c = 9'b00011_001_0; nx = 2; end
        default: nx = 0;
      endcase
    end
  endtask

  // Per-cycle compare and model advance, mid low phase.
  always @(negedge clk) begin
    logic [8:0] e_c;
    int         e_nx;
    #2;
    model_eval(e_c, e_nx);
    chk("ctrl16", 32'(c16), 32'(e_c));
    chk("ctrl4", 32'(c4), 32'(e_c));
    chk("state16", 32'(st16), 32'(m_mode));
    chk("state4", 32'(st4), 32'(m_mode));
    chk("cnt16", 32'(cnt16), 32'(m_cnt));
    chk("cnt4", 32'(cnt4), 32'(m_cnt4));
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      m_mode = e_nx;
      if (!e_c[8]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
  end

  task automatic cyc(input bit r, input bit hs, input bit fi, input bit fx, input bit im,
                     input bit dq, input bit dr, input bit ms, input bit md, input bit tr);
    @(negedge clk);
    rst = r; hz_stall = hs; hz_flush_ifid = fi; hz_flush_idex = fx; imem_ready = im;
    dmem_req_MEM = dq; dmem_ready = dr; md_start_EX = ms; md_done = md; trap_req = tr;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    #3;
    chk("rst_state", 32'(st16), 0);
    chk("rst_cnt", 32'(cnt16), 0);
    chk("rst_ctrl", 32'(c16), 0);
  endtask

  initial begin
    rst = 1'b1; hz_stall = 0; hz_flush_ifid = 0; hz_flush_idex = 0; imem_ready = 1;
    dmem_req_MEM = 0; dmem_ready = 0; md_start_EX = 0; md_done = 0; trap_req = 0;

    // Load waits three cycles on data memory.
    do_reset();
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    #3 chk("ld_c1_en", 32'(c16[8:4]), 0);
    repeat (2) begin
      cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      #3 chk("ld_wait_state", 32'(st16), 1);
      chk("ld_wait_en", 32'(c16[8:4]), 0);
    end
    cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    #3 chk("ld_done_en", 32'(c16[8:4]), 32'h1f);
    chk("ld_done_state", 32'(st16), 1);
    idle();
    #3 chk("ld_after_state", 32'(st16), 0);
    chk("ld_cnt", 32'(cnt16), 3);

    // Mul/div busy for five cycles.
    do_reset();
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    #3 chk("md_c1", 32'({c16[8], c16[4], c16[1]}), 32'b011);
    repeat (4) begin
      cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      #3 chk("md_busy", 32'({c16[8], c16[4], c16[1]}), 32'b011);
      chk("md_state", 32'(st16), 2);
    end
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    #3 chk("md_done_ctrl", 32'(c16), 32'h1f0);
    idle();
    #3 chk("md_cnt", 32'(cnt16), 5);

    // Trap beats a coincident hazard stall and branch flush.
    do_reset();
    cyc(0, 1, 1, 0, 1, 0, 0, 0, 0, 1);
    #3 chk("trap_redir", 32'({c16[0], c16[3:1]}), 32'b1111);
    idle();
    #3 chk("trap_state", 32'(st16), 3);
    chk("trap_one_shot", 32'(c16[0]), 0);
    idle();
    #3 chk("trap_back", 32'(st16), 0);

    // Hazard stall with ID/EX bubble.
    cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    #3 chk("hz_ctrl", 32'({c16[8], c16[7], c16[2], c16[5]}), 32'b0011);

    // Instruction fetch starved long enough to saturate the narrow counter.
    do_reset();
    repeat (20) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3 chk("imem_flush", 32'(c4[3]), 1);
    end
    idle();
    #3 chk("sat_cnt4", 32'(cnt4), 15);
    chk("cnt16_20", 32'(cnt16), 20);

    // Reset in the middle of a mul/div wait.
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    #3 chk("mdrst_pre", 32'(st16), 2);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    idle();
    #3 chk("mdrst_state", 32'(st16), 0);
    chk("mdrst_cnt", 32'(cnt16), 0);
    chk("mdrst_redir", 32'(c16[0]), 0);

    // Random traffic.
    repeat (1500) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom % 4 == 0), ($urandom % 4 == 0),
          ($urandom % 2 == 0), ($urandom % 5 != 0), ($urandom % 3 == 0),
          ($urandom % 2 == 0), ($urandom % 6 == 0), ($urandom % 3 == 0),
          ($urandom % 12 == 0));
    end

    @(negedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 hz_stall, hz_flush_ifid, hz_flush_idex  in  1 each  stall/flush requests from the hazard unit.
REQ-005 imem_ready  in  1  instruction fetch data valid this cycle.
REQ-006 dmem_req_MEM  in  1  load/store occupies the MEM stage.
REQ-007 dmem_ready  in  1  data memory completes the MEM access this cycle.
REQ-008 md_start_EX  in  1  multi-cycle mul/div instruction in the EX stage.
REQ-009 md_done  in  1  mul/div result valid.
REQ-010 trap_req  in  1  exception raised by the instruction in MEM.
REQ-011 en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB  out  1 each  stage-register load enables.
REQ-012 flush_IFID, flush_IDEX, flush_EXMEM  out  1 each  insert a bubble into that register on this edge.
REQ-013 redirect_trap  out  1  load the trap vector into the PC on this edge.
REQ-014 state  out  2  current FSM state.
REQ-015 stall_cnt  out  CNT_W  count of cycles with en_PC=0.

Function
REQ-016 Outputs SHALL be combinational from the inputs and the registered state, taking effect in the same cycle.
REQ-017 FSM states: RUN=0, MEMWAIT=1, MDBUSY=2, TRAP=3.
REQ-018 In RUN, requests SHALL be resolved in this priority: trap_req > dmem wait > md_start_EX > hz_stall > imem_ready low; branch flushes are resolved separately (REQ-024).
REQ-019 trap_req in RUN: flush_IFID, flush_IDEX and flush_EXMEM = 1; redirect_trap = 1 for exactly one cycle; en_MEMWB = 0; go to TRAP.
REQ-020 TRAP lasts one cycle: all enables = 1, all flushes = 0, trap_req ignored; then go to RUN.
REQ-021 dmem_req_MEM=1 and dmem_ready=0 in RUN: all enables = 0; go to MEMWAIT.
  - MEMWAIT with dmem_ready=0: all enables stay 0.
  - MEMWAIT with dmem_ready=1: all enables = 1 in that same cycle; go to RUN.
  - dmem_req_MEM=1 and dmem_ready=1 in RUN: no stall.
REQ-022 md_start_EX=1 in RUN (no higher-priority request): en_PC, en_IFID, en_IDEX = 0; flush_EXMEM = 1; en_MEMWB = 1; go to MDBUSY.
  - MDBUSY with md_done=0: same outputs as on entry.
  - MDBUSY with md_done=1: all enables = 1, flushes = 0; go to RUN.
  - md_done=1 in the same cycle as md_start_EX: no stall; stay in RUN.
REQ-023 hz_stall=1 in RUN: en_PC = 0 and en_IFID = 0; flush_IDEX = hz_flush_idex; the remaining stages are enabled.
REQ-024 hz_flush_ifid=1 in RUN: flush_IFID = 1, but only when no trap, dmem wait or md_start_EX is active; a frozen fetch SHALL NOT be flushed.
REQ-025 imem_ready=0 in RUN (no higher-priority request): en_PC = 0; flush_IFID = 1; downstream stages are enabled.
REQ-026 trap_req during MEMWAIT or MDBUSY SHALL be ignored until the FSM returns to RUN.
REQ-027 stall_cnt SHALL increment by 1 on each edge where en_PC = 0, and SHALL saturate at all-ones without wrapping.

Reset
REQ-028 While rst=1: state = RUN, stall_cnt = 0, all enables = 0, all flushes = 0, redirect_trap = 0.
REQ-029 rst asserted mid-MEMWAIT or mid-MDBUSY SHALL return the FSM to RUN on the next edge, with no redirect_trap.

Structure
REQ-030 Package pipe_ctrl_pkg SHALL hold the state typedef/encodings and the default for CNT_W.
REQ-031 The saturating counter SHALL be a sub-module named sat_counter; the FSM and output decode stay in pipe_ctrl.

Verification
REQ-032 Load with dmem_ready low for 3 cycles -> all enables 0 for 3 cycles, state=1; on the 4th cycle enables 1 and state returns to 0; stall_cnt=3.
REQ-033 md_start_EX, then md_done after 5 cycles -> flush_EXMEM=1 and en_PC=0 for 5 cycles, en_MEMWB=1 throughout; stall_cnt=5.
REQ-034 trap_req together with hz_stall and hz_flush_ifid -> a single cycle with redirect_trap=1 and the three flushes=1; next cycle state=3; the cycle after, state=0.
REQ-035 hz_stall=1 with hz_flush_idex=1 -> en_PC=0, en_IFID=0, flush_IDEX=1, en_EXMEM=1.
REQ-036 With CNT_W=4, hold imem_ready=0 for 20 cycles -> stall_cnt saturates at 15; flush_IFID=1 on every one of those cycles.
REQ-037 Assert rst during MDBUSY -> state=0 and stall_cnt=0 on the next edge.
